sreg_loader: RTL and testbench
==============================

# sreg_loader

Write-side front end for the vertex processor's 16 x 128-bit special register file. It accepts a load command (base address, register count), collects 32-bit beats from the host/command bus, and packs each group of four beats into one 128-bit word. It then drives the register file's write port (`we`, `w_addr`, `data_in`) one register at a time, auto-incrementing the address. It is the only writer of the special register file; the file's combinational read port is untouched.

## Interface
- `addr_w`, 4, register file address width (16 registers)
- `data_w`, 128, register width
- `bus_w`, 32, host beat width; `data_w` must be an integer multiple of `bus_w`; BEATS = `data_w/bus_w` (4)

- `clk`  in  1  rising-edge clock, shared with the register file
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  load command present
- `cmd_ready`  out  1  loader idle, command accepted on `cmd_valid & cmd_ready`
- `cmd_addr`  in  addr_w  first register to write
- `cmd_len`  in  addr_w  number of registers minus 1 (0 = one register, 15 = all 16)
- `beat_valid`  in  1  host beat present
- `beat_ready`  out  1  loader accepts a beat this cycle
- `beat_data`  in  bus_w  beat payload
- `we`  out  1  register file write enable
- `w_addr`  out  addr_w  register file write address
- `wdata`  out  data_w  register file write data (to `data_in`)
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse on the final write of a command

## Operation
- States: IDLE, COLLECT, WRITE.
- IDLE: `cmd_ready`=1, `beat_ready`=0. On a command handshake, latch `cmd_addr` into the address counter and `cmd_len` into the remaining counter. Clear the beat counter and go to COLLECT.
- COLLECT: `beat_ready`=1. Each `beat_valid & beat_ready` stores `beat_data` into slot k of the assembly register and increments k. Slot 0 is bits [bus_w-1:0]; the packing is LSB-first.
  - When beat BEATS-1 is accepted, go to WRITE.
  - `beat_valid` low stalls indefinitely; no timeout.
- WRITE: `beat_ready`=0. `we`=1 with `w_addr` = address counter and `wdata` = assembly register, for exactly one cycle.
  - If remaining == 0: pulse `done` and go to IDLE.
  - Otherwise: decrement remaining, increment the address modulo 2^addr_w (15 wraps to 0), clear k, and go to COLLECT.
- `busy` = state != IDLE.
- Beats offered in IDLE are not accepted (`beat_ready`=0). They are held off, not dropped.
- `cmd_valid` while busy is ignored; `cmd_ready`=0.
- `we` is high only in WRITE; `w_addr`/`wdata` hold their last values otherwise.

## Timing
- `cmd_ready`, `beat_ready`, `we`, `busy`, and `done` are decoded from state only; there is no combinational path from any input.
- Minimum latency:
  - Command accept at edge 0; first beat accepted at edge 1 at the earliest.
  - Fourth beat at edge 4; `we` is high in the cycle after edge 4 and the register file captures at edge 5.
- Minimum throughput: BEATS+1 cycles per register (5), i.e. 80 cycles for a full 16-register load.
- Back-to-back commands: the earliest next command handshake is the edge right after the WRITE cycle that pulsed `done`.
- Reset: `rst` sampled high at an edge forces IDLE and clears the address, remaining, and beat counters, the assembly register, `w_addr`, and `wdata`.
  - After reset: `we`=0, `done`=0, `busy`=0, `beat_ready`=0, `cmd_ready`=1.
  - Reset mid-command abandons it with no further write. A register already written stays written.
  - `cmd_ready` is forced 0 while `rst` is high.

## Configuration
- `SREG_LOADER_MSB_FIRST_EN` defined: packing is MSB-first; beat 0 lands in bits [data_w-1:data_w-bus_w] and beat BEATS-1 in [bus_w-1:0].
- Not defined: LSB-first packing as described above. Handshake and timing are identical in both modes.

## Structure
- Shared package `sreg_pkg`: state encoding (IDLE=0, COLLECT=1, WRITE=2), the `BEATS` constant, and the default widths shared with the register file.
- One sub-module, `beat_packer`: beat counter plus assembly register, with inputs load-strobe/clear/data and outputs `full` and the packed word. The packing-order macro is handled there.
- The top level holds the FSM, the address and remaining counters, and the output registers.

## Test plan
- Single load: cmd_addr=3, cmd_len=0, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> one `we` with w_addr=3, wdata=0x44444444_33333333_22222222_11111111, `done` in the same cycle, and exactly 5 cycles from command accept to write.
- Wrap: cmd_addr=14, cmd_len=3, 16 beats -> writes to 14, 15, 0, 1 in order; `done` only on the write to 1.
- Stalls: beat_valid toggling randomly during a 2-register load -> same wdata as without stalls; `we` never asserted with fewer than 4 beats collected.
- Busy rejection: cmd_valid held high throughout a load with a different addr -> `cmd_ready`=0 until after `done`; the second command starts next cycle with its own address.
- Reset mid-operation: rst asserted after beat 2 of register 1 in a cmd_len=2 load -> no further `we`; post-reset outputs as specified; a fresh load then works.
- Macro on: repeat the single load with `SREG_LOADER_MSB_FIRST_EN` -> wdata=0x11111111_22222222_33333333_44444444.

Source files
------------

// File: rtl/sreg_pkg.sv
// Shared constants and state encoding for the special-register loader and its register file.
package sreg_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 128;
   localparam int BUS_W  = 32;
   localparam int BEATS  = DATA_W / BUS_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2
   } state_e;

endpackage

// File: rtl/beat_packer.sv
// Beat counter and assembly register that pack bus beats into one register-wide word.
// Packing order: LSB-first by default, MSB-first when SREG_LOADER_MSB_FIRST_EN is defined.
module beat_packer
   import sreg_pkg::*;
#(
   parameter int data_w = DATA_W,
   parameter int bus_w  = BUS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [bus_w-1:0]  data,
   output logic              full,
   output logic [data_w-1:0] word
);

   localparam int beats = data_w / bus_w;
   localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;

   logic [cnt_w-1:0]  cnt_q, cnt_d;
   logic [data_w-1:0] word_q, word_d;
   logic              last;

   assign last = (cnt_q == cnt_w'(beats - 1));
   // full flags the beat that completes the word, so the FSM can leave COLLECT on that same edge
   assign full = load && last;
   assign word = word_q;

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clear) begin
         cnt_d = '0;
      end else if (load) begin
         for (int i = 0; i < beats; i++) begin
            if (cnt_q == cnt_w'(i)) begin
`ifdef SREG_LOADER_MSB_FIRST_EN
               word_d[(beats-1-i)*bus_w +: bus_w] = data;
`else
               word_d[i*bus_w +: bus_w] = data;
`endif
            end
         end
         cnt_d = last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/sreg_loader.sv
// Write-side front end of the special register file: takes a load command, packs host beats
// into registers and writes them with an auto-incrementing address. Packing order is set by
// SREG_LOADER_MSB_FIRST_EN inside beat_packer.
module sreg_loader
   import sreg_pkg::*;
#(
   parameter int addr_w = ADDR_W,
   parameter int data_w = DATA_W,
   parameter int bus_w  = BUS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [addr_w-1:0] cmd_addr,
   input  logic [addr_w-1:0] cmd_len,
   input  logic              beat_valid,
   output logic              beat_ready,
   input  logic [bus_w-1:0]  beat_data,
   output logic              we,
   output logic [addr_w-1:0] w_addr,
   output logic [data_w-1:0] wdata,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [addr_w-1:0] addr_q, addr_d;
   logic [addr_w-1:0] rem_q, rem_d;
   logic [addr_w-1:0] w_addr_q, w_addr_d;
   logic [data_w-1:0] wdata_q, wdata_d;

   logic              pack_load;
   logic              pack_clear;
   logic              pack_full;
   logic [data_w-1:0] pack_word;

   beat_packer #(
      .data_w (data_w),
      .bus_w  (bus_w)
   ) u_packer (
      .clk   (clk),
      .rst   (rst),
      .load  (pack_load),
      .clear (pack_clear),
      .data  (beat_data),
      .full  (pack_full),
      .word  (pack_word)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      w_addr_d   = w_addr_q;
      wdata_d    = wdata_q;
      pack_load  = 1'b0;
      pack_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d     = cmd_addr;
               rem_d      = cmd_len;
               pack_clear = 1'b1;
               state_d    = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            pack_load = beat_valid;
            if (pack_full) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // remember what was written so the port holds it while the next word assembles
            w_addr_d = addr_q;
            wdata_d  = pack_word;
            if (rem_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               rem_d      = rem_q - 1'b1;
               addr_d     = addr_q + 1'b1;
               pack_clear = 1'b1;
               state_d    = ST_COLLECT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         w_addr_q <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         w_addr_q <= w_addr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE) && !rst;
   assign beat_ready = (state_q == ST_COLLECT);
   assign we         = (state_q == ST_WRITE);
   assign busy       = (state_q != ST_IDLE);
   assign done       = we && (rem_q == '0);
   assign w_addr     = we ? addr_q : w_addr_q;
   assign wdata      = we ? pack_word : wdata_q;

endmodule

// File: tb/tb_sreg_loader.sv
// Self-checking bench for sreg_loader: directed command sequences with random beat payloads,
// checked against a packing/addressing model computed from plain arithmetic.
module tb_sreg_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [3:0]   cmd_addr;
   logic [3:0]   cmd_len;
   logic         beat_valid;
   logic         beat_ready;
   logic [31:0]  beat_data;
   logic         we;
   logic [3:0]   w_addr;
   logic [127:0] wdata;
   logic         busy;
   logic         done;

   sreg_loader dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .beat_valid (beat_valid),
      .beat_ready (beat_ready),
      .beat_data  (beat_data),
      .we         (we),
      .w_addr     (w_addr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // observed write log and command-accept log, gathered on the falling edge
   logic [3:0]   wr_addr_q[$];
   logic [127:0] wr_data_q[$];
   logic         wr_done_q[$];
   int           wr_acc_q[$];
   int           wr_cyc_q[$];
   int           acc_cyc_q[$];

   int           cyc = 0;
   int           acc = 0;
   int           hold_err = 0;
   int           done_err = 0;
   logic         have_last = 1'b0;
   logic [3:0]   last_addr;
   logic [127:0] last_data;

   logic [31:0]  bts[64];

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         acc       = 0;
         have_last = 1'b0;
      end else begin
         if (we) begin
            wr_addr_q.push_back(w_addr);
            wr_data_q.push_back(wdata);
            wr_done_q.push_back(done);
            wr_acc_q.push_back(acc);
            wr_cyc_q.push_back(cyc);
            acc       = 0;
            last_addr = w_addr;
            last_data = wdata;
            have_last = 1'b1;
         end else if (have_last && (w_addr !== last_addr || wdata !== last_data)) begin
            hold_err++;
         end
         if (done && !we) done_err++;
         if (beat_valid && beat_ready) acc++;
         if (cmd_valid && cmd_ready) acc_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference: four beats placed into 32-bit lanes of a 128-bit word
   function automatic logic [127:0] model_word(input int first);
      logic [127:0] w;
      w = '0;
      for (int i = 0; i < 4; i++) begin
`ifdef SREG_LOADER_MSB_FIRST_EN
         w = w | (128'(bts[first+i]) << (32 * (3 - i)));
`else
         w = w | (128'(bts[first+i]) << (32 * i));
`endif
      end
      return w;
   endfunction

   function automatic int qget(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   task automatic wait_cmd_hs();
      logic r;
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         r = cmd_ready;
         step();
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("cmd_timeout", ok, 1'b1);
   endtask

   task automatic do_cmd(input logic [3:0] a, input logic [3:0] l);
      cmd_addr  = a;
      cmd_len   = l;
      cmd_valid = 1'b1;
      wait_cmd_hs();
      cmd_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input int max_stall);
      logic r;
      logic ok;
      repeat ($urandom_range(0, max_stall)) begin
         beat_valid = 1'b0;
         beat_data  = $urandom;
         step();
      end
      beat_valid = 1'b1;
      beat_data  = d;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         r = beat_ready;
         step();
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      beat_valid = 1'b0;
      if (!ok) chk("beat_timeout", ok, 1'b1);
   endtask

   task automatic send_regs(input int first, input int nregs, input int max_stall);
      for (int i = 0; i < 4 * nregs; i++) send_beat(bts[first+i], max_stall);
   endtask

   task automatic check_write(input string tag, input int idx, input logic [3:0] ea,
                              input logic [127:0] ed, input logic edn);
      if (idx < wr_addr_q.size()) begin
         chk({tag, "_addr"}, wr_addr_q[idx], ea);
         chk({tag, "_data"}, wr_data_q[idx], ed);
         chk({tag, "_done"}, wr_done_q[idx], edn);
         chk({tag, "_beats"}, wr_acc_q[idx], 4);
      end else begin
         chk({tag, "_missing"}, wr_addr_q.size(), idx + 1);
      end
   endtask

   initial begin
      int n0;
      int k0;
      logic [3:0] ra;

      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_addr   = '0;
      cmd_len    = '0;
      beat_valid = 1'b0;
      beat_data  = '0;
      for (int i = 0; i < 64; i++) bts[i] = $urandom;

      // reset state, with reset still applied
      step();
      step();
      chk("rst_we", we, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_beat_ready", beat_ready, 1'b0);
      chk("rst_cmd_ready_forced", cmd_ready, 1'b0);
      chk("rst_w_addr", w_addr, 4'h0);
      chk("rst_wdata", wdata, 128'h0);
      rst = 1'b0;
      #1;
      chk("idle_cmd_ready", cmd_ready, 1'b1);

      // a beat offered while idle must be held off
      beat_valid = 1'b1;
      beat_data  = 32'hDEAD_BEEF;
      step();
      step();
      chk("idle_beat_ready", beat_ready, 1'b0);

      // single load at minimum latency
      bts[0] = 32'h1111_1111;
      bts[1] = 32'h2222_2222;
      bts[2] = 32'h3333_3333;
      bts[3] = 32'h4444_4444;
      n0 = wr_addr_q.size();
      k0 = acc_cyc_q.size();
      do_cmd(4'd3, 4'd0);
      send_regs(0, 1, 0);
      repeat (3) step();
      chk("single_count", wr_addr_q.size() - n0, 1);
      check_write("single", n0, 4'd3, model_word(0), 1'b1);
`ifdef SREG_LOADER_MSB_FIRST_EN
      chk("single_const", wr_data_q[n0], 128'h11111111_22222222_33333333_44444444);
`else
      chk("single_const", wr_data_q[n0], 128'h44444444_33333333_22222222_11111111);
`endif
      chk("single_latency", qget(wr_cyc_q, n0) - qget(acc_cyc_q, k0), 5);

      // address wrap across the top of the file
      n0 = wr_addr_q.size();
      do_cmd(4'd14, 4'd3);
      send_regs(4, 4, 0);
      repeat (3) step();
      chk("wrap_count", wr_addr_q.size() - n0, 4);
      for (int r = 0; r < 4; r++) begin
         check_write($sformatf("wrap%0d", r), n0 + r, 4'((14 + r) % 16), model_word(4 + 4 * r),
                     (r == 3));
      end

      // random beat_valid stalls over a two-register load
      n0 = wr_addr_q.size();
      ra = 4'($urandom_range(0, 15));
      do_cmd(ra, 4'd1);
      send_regs(20, 2, 3);
      repeat (3) step();
      chk("stall_count", wr_addr_q.size() - n0, 2);
      check_write("stall0", n0, ra, model_word(20), 1'b0);
      check_write("stall1", n0 + 1, 4'(ra + 4'd1), model_word(24), 1'b1);

      // command held valid across a busy load is refused until the loader is idle again
      n0 = wr_addr_q.size();
      k0 = acc_cyc_q.size();
      cmd_addr  = 4'd2;
      cmd_len   = 4'd0;
      cmd_valid = 1'b1;
      wait_cmd_hs();
      cmd_addr = 4'd9;
      send_regs(28, 1, 0);
      wait_cmd_hs();
      cmd_valid = 1'b0;
      send_regs(32, 1, 1);
      repeat (3) step();
      chk("busy_accepts", acc_cyc_q.size() - k0, 2);
      chk("busy_next_cmd_cycle", qget(acc_cyc_q, k0 + 1), qget(wr_cyc_q, n0) + 1);
      check_write("busy_first", n0, 4'd2, model_word(28), 1'b1);
      check_write("busy_second", n0 + 1, 4'd9, model_word(32), 1'b1);

      // reset after two beats of the second register abandons the command
      n0 = wr_addr_q.size();
      do_cmd(4'd5, 4'd2);
      send_regs(36, 1, 0);
      send_beat(bts[40], 0);
      send_beat(bts[41], 0);
      rst = 1'b1;
      step();
      chk("midrst_cmd_ready_forced", cmd_ready, 1'b0);
      chk("midrst_we", we, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_beat_ready", beat_ready, 1'b0);
      chk("midrst_w_addr", w_addr, 4'h0);
      chk("midrst_wdata", wdata, 128'h0);
      rst = 1'b0;
      #1;
      chk("midrst_cmd_ready", cmd_ready, 1'b1);
      repeat (8) step();
      chk("midrst_count", wr_addr_q.size() - n0, 1);
      check_write("midrst_reg0", n0, 4'd5, model_word(36), 1'b0);

      // fresh load after the abandoned command
      n0 = wr_addr_q.size();
      do_cmd(4'd9, 4'd0);
      send_regs(48, 1, 2);
      repeat (3) step();
      chk("fresh_count", wr_addr_q.size() - n0, 1);
      check_write("fresh", n0, 4'd9, model_word(48), 1'b1);

      chk("hold_violations", hold_err, 0);
      chk("stray_done", done_err, 0);

      step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
